// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter that drives the select of the shared dual 4:1 nibble mux.
// A grant is held while requested, limited by HOLD_MAX, with a one-cycle gap between grants.
module mux_4_1_rr_arbiter #(
   parameter int unsigned HOLD_MAX = 15,
   parameter int unsigned CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] en,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {StIdle, StGrant} state_t;

   localparam logic [CNT_W-1:0] HoldLim = CNT_W'(HOLD_MAX);
   localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

   state_t           state;
   logic [1:0]       last_owner;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       ereq;
   logic [1:0]       winner;
   logic [1:0]       idx;
   logic             found;

   assign ereq = req & en;

   // Circular search starting just after the most recent owner.
   always_comb begin
      winner = last_owner;
      found  = 1'b0;
      idx    = last_owner;
      for (int k = 1; k <= 4; k++) begin
         idx = last_owner + 2'(k);
         if (!found && ereq[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= StIdle;
         grant      <= 4'b0000;
         sel        <= 2'd0;
         busy       <= 1'b0;
         timeout    <= 1'b0;
         cnt        <= '0;
         last_owner <= 2'd3;
      end else begin
         unique case (state)
            StIdle: begin
               timeout <= 1'b0;
               if (|ereq) begin
                  grant      <= 4'b0001 << winner;
                  sel        <= winner;
                  last_owner <= winner;
                  busy       <= 1'b1;
                  cnt        <= CNT_W'(1);
                  state      <= StGrant;
               end else begin
                  grant <= 4'b0000;
                  busy  <= 1'b0;
               end
            end
            StGrant: begin
               // sel always holds the current owner while granted.
               if (!ereq[sel]) begin
                  grant   <= 4'b0000;
                  busy    <= 1'b0;
                  cnt     <= '0;
                  timeout <= 1'b0;
                  state   <= StIdle;
               end else if ((HOLD_MAX != 0) && (cnt == HoldLim)) begin
                  grant   <= 4'b0000;
                  busy    <= 1'b0;
                  cnt     <= '0;
                  timeout <= 1'b1;
                  state   <= StIdle;
               end else if (cnt != CntMax) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Randomized and directed bench for mux_4_1_rr_arbiter; three instances with HOLD_MAX 3, 0, 15
// are compared every cycle against an owner/hold-time reference model.
module tb_mux_4_1_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] en  = 4'hF;

   logic [3:0] gnt [3];
   logic [1:0] sl  [3];
   logic       bz  [3];
   logic       tmo [3];

   int checks   = 0;
   int failures = 0;

   // Reference model: owner index (-1 = nobody), cycles held, last owner, sel, timeout flag.
   int owner [3];
   int held  [3];
   int last  [3];
   int msel  [3];
   int mto   [3];
   int hmx   [3] = '{3, 0, 15};

   always #5 clk = ~clk;

   mux_4_1_rr_arbiter #(.HOLD_MAX(3), .CNT_W(4)) dut3 (
      .clk(clk), .rst(rst), .req(req), .en(en),
      .grant(gnt[0]), .sel(sl[0]), .busy(bz[0]), .timeout(tmo[0])
   );
   mux_4_1_rr_arbiter #(.HOLD_MAX(0), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .req(req), .en(en),
      .grant(gnt[1]), .sel(sl[1]), .busy(bz[1]), .timeout(tmo[1])
   );
   mux_4_1_rr_arbiter #(.HOLD_MAX(15), .CNT_W(4)) dut15 (
      .clk(clk), .rst(rst), .req(req), .en(en),
      .grant(gnt[2]), .sel(sl[2]), .busy(bz[2]), .timeout(tmo[2])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 3; m++) begin
         owner[m] = -1;
         held[m]  = 0;
         last[m]  = 3;
         msel[m]  = 0;
         mto[m]   = 0;
      end
   endtask

   task automatic model_step(input logic [3:0] e);
      for (int m = 0; m < 3; m++) begin
         if (owner[m] >= 0) begin
            if (!e[owner[m]]) begin
               owner[m] = -1;
               mto[m]   = 0;
            end else if (hmx[m] != 0 && held[m] == hmx[m]) begin
               owner[m] = -1;
               mto[m]   = 1;
            end else begin
               held[m]++;
            end
         end else begin
            mto[m] = 0;
            if (e != 4'b0000) begin
               for (int k = 1; k <= 4; k++) begin
                  if (owner[m] < 0 && e[(last[m] + k) % 4]) owner[m] = (last[m] + k) % 4;
               end
               last[m] = owner[m];
               msel[m] = owner[m];
               held[m] = 1;
            end
         end
      end
   endtask

   task automatic check_all(input string ph);
      logic [3:0] eg;
      for (int m = 0; m < 3; m++) begin
         eg = (owner[m] >= 0) ? (4'b0001 << owner[m]) : 4'b0000;
         check($sformatf("%s.d%0d.grant", ph, m), 32'(gnt[m]), 32'(eg));
         check($sformatf("%s.d%0d.sel", ph, m), 32'(sl[m]), 32'(msel[m]));
         check($sformatf("%s.d%0d.busy", ph, m), 32'(bz[m]), 32'(owner[m] >= 0));
         check($sformatf("%s.d%0d.timeout", ph, m), 32'(tmo[m]), 32'(mto[m]));
      end
   endtask

   task automatic cycle(input string ph);
      @(posedge clk);
      model_step(req & en);
      #1;
      check_all(ph);
   endtask

   task automatic cycles(input string ph, input int n);
      for (int i = 0; i < n; i++) cycle(ph);
   endtask

   // Assert reset between edges and verify outputs clear without a clock.
   task automatic async_reset(input string ph);
      @(posedge clk);
      model_step(req & en);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check_all({ph, ".async"});
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      #1 rst = 1'b1;
      #1 check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Single requester, released after 5 granted cycles.
      req = 4'b0001; en = 4'hF;
      cycle("single");
      check("single.first_grant", 32'(gnt[2]), 32'h1);
      cycles("single", 4);
      req = 4'b0000;
      cycles("single_rel", 3);

      // All requesting: rotation with timeouts on the HOLD_MAX=3 instance.
      async_reset("rot");
      req = 4'b1111;
      cycles("rot", 22);

      // No pre-emption: requester 0 waits for owner 2.
      async_reset("nopre");
      req = 4'b0000;
      cycles("nopre", 1);
      req = 4'b0100;
      cycles("nopre", 2);
      req = 4'b0101;
      cycles("nopre", 2);
      req = 4'b0001;
      cycles("nopre", 3);
      check("nopre.after_gap", 32'(gnt[2]), 32'h1);

      // Enable drop on the owner.
      async_reset("endrop");
      req = 4'b0010;
      cycles("endrop", 2);
      en = 4'b1101;
      cycles("endrop", 5);
      en = 4'hF;

      // Long hold: HOLD_MAX=0 never times out.
      async_reset("long");
      req = 4'b1000;
      cycles("long", 40);
      check("long.unlimited", 32'(gnt[1]), 32'h8);

      // Reset mid-grant, then restart favours requester 0 side.
      async_reset("midrst");
      req = 4'b1010;
      cycle("midrst");
      check("midrst.first", 32'(gnt[0]), 32'h2);
      cycles("midrst", 4);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         if ($urandom_range(0, 9) == 0) en = 4'($urandom);
         if ($urandom_range(0, 149) == 0) async_reset("rnd");
         else cycle("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_4_1_rr_arbiter.md
Name: mux_4_1_rr_arbiter

Overview:
- Round-robin arbiter that shares the dual 4:1 nibble mux between four requesters.
- Drives the mux select, so only the granted requester's pair of 4-bit buses reaches the two shared outputs.
- A grant is held while its requester keeps asking, subject to a maximum hold time.
- One idle gap cycle separates consecutive grants, so downstream logic sees a clean handover.

Parameters:
HOLD_MAX, 15, maximum consecutive cycles one grant may stay asserted; 0 means unlimited.
CNT_W, 4, hold counter width; HOLD_MAX must be at most 2^CNT_W - 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  4  per-requester request, level; held high while access is wanted.
en  input  4  per-requester enable mask; an effective request is req[i] & en[i].
grant  output  4  one-hot grant, registered; all zero when nobody owns the mux.
sel  output  2  mux select, registered; index of the current or most recent owner.
busy  output  1  high whenever grant is non-zero.
timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX.

Behaviour:
- Reset (asynchronous): grant=0, sel=0, busy=0, timeout=0, hold counter=0, state=IDLE, last_owner=3. The first arbitration therefore favours requester 0.
- Effective request: ereq = req & en. All decisions use ereq sampled at the clock edge.
- State IDLE:
  - If ereq==0: stay in IDLE. grant=0, sel holds its last value.
  - Else: pick the first set bit of ereq, searching circularly from last_owner+1.
  - On that edge: grant=onehot(winner), sel=winner, last_owner=winner, counter=1, state=GRANT.
  - Latency from req rising to grant high: exactly 1 clock.
- State GRANT (owner o):
  - Release: if ereq[o]==0, either because req dropped or en dropped. Next edge: grant=0, state=IDLE, counter=0, no timeout pulse.
  - Timeout: else if HOLD_MAX!=0 and counter==HOLD_MAX. Next edge: grant=0, state=IDLE, timeout=1 for exactly that one cycle.
  - Otherwise: stay in GRANT and increment counter. With HOLD_MAX=0 the counter saturates at 2^CNT_W-1 and never times out.
  - grant[o] is therefore high for at most HOLD_MAX consecutive cycles.
- Gap: every exit from GRANT spends exactly one cycle in IDLE with grant=0 before any new grant. A requester still asking after a timeout is eligible again, but only after the other pending requesters in round-robin order.
- sel never changes while grant is non-zero. sel changes only on the edge that issues a new grant, so the mux outputs stay stable for the whole grant.
- Requests or enables from non-owners during GRANT are ignored until the next IDLE arbitration. There is no pre-emption.
- Release and timeout eligible on the same edge: release wins and timeout stays 0.
- busy = |grant, registered consistently with grant (no combinational path from req).
- timeout is high only in the gap cycle following a HOLD_MAX revoke; it is 0 at all other times.
- Reset asserted mid-grant: all outputs return to their reset values immediately, without waiting for clk. After reset deasserts, arbitration restarts with requester 0 first.
- A winner must exist whenever ereq is non-zero. An invalid one-hot grant is never produced.

Test Plan:
- Reset then req=4'b0001, en=4'hF: grant=0001 and sel=0 one clock later. Drop req after 5 granted cycles: grant=0000 next cycle, timeout=0.
- req=4'b1111 held, HOLD_MAX=3:
  - Grants go 0,1,2,3,0 in that order.
  - Each grant lasts 3 cycles and is followed by one gap cycle with timeout=1.
  - sel steps 0,1,2,3,0.
- Owner 2 granted with req=4'b0100; raise req[0] mid-grant: grant stays 0100. After owner 2 releases there is one gap cycle, then grant=0001.
- Owner 1 granted; clear en[1] while req[1] stays high: grant=0000 next cycle and timeout=0. Requester 1 is not regranted while en[1]=0.
- HOLD_MAX=0, req=4'b1000 held for 40 cycles: grant=1000 continuously, timeout never asserts, counter saturates without wrapping.
- Assert rst asynchronously mid-grant between edges: grant, sel, busy and timeout are 0 immediately. After release with req=4'b1010, the first grant is 0010.
